fpu_add_arbiter: RTL
====================

Name: fpu_add_arbiter

Overview:
- Shares one fpu_sp_add single-precision adder between NUM_REQ requesters.
- Arbitrates operand requests round-robin and drives the adder's din1/din2/dval.
- Tracks in-flight operations in an in-order tag FIFO and routes each rdy/result back to the requester that issued it.
- Sits between the client blocks and the single fpu_sp_add instance.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- MAX_OUTSTANDING, 1, maximum operations in flight in the adder (1..8). Set to 1 for a non-pipelined adder.
- TAG_W, $clog2(NUM_REQ), requester-index width (derived, not overridable).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  per-requester operation request
- req_a  in  32*NUM_REQ  operand A per requester (slice i = [32*i+31:32*i])
- req_b  in  32*NUM_REQ  operand B per requester
- req_ready  out  NUM_REQ  one-hot accept; handshake completes when req_valid[i] & req_ready[i]
- resp_valid  out  NUM_REQ  one-hot, one-cycle result strobe
- resp_result  out  32  result for the strobed requester
- fpu_din1  out  32  adder operand 1
- fpu_din2  out  32  adder operand 2
- fpu_dval  out  1  one-cycle issue strobe to adder
- fpu_result  in  32  adder result
- fpu_rdy  in  1  adder completion; one-cycle pulse per operation, in issue order
- busy  out  1  high while count != 0 or fpu_dval is high
- err_spurious  out  1  sticky; set when fpu_rdy arrives with an empty tag FIFO

Behaviour:
- Reset values: req_ready=0, resp_valid=0, resp_result=0, fpu_din1=0, fpu_din2=0, fpu_dval=0, err_spurious=0. Round-robin pointer=NUM_REQ-1, so requester 0 has first priority. Outstanding count=0, tag FIFO empty.
- Reset asserted mid-operation clears all state immediately. Any result returning afterwards is not routed. The adder shares rst_n.
- Issue eligibility: count < MAX_OUTSTANDING, using the registered count. A same-cycle fpu_rdy does not free the slot for that cycle's issue.
- Arbitration (combinational):
  - When eligible, grant the first i with req_valid[i], searching from ptr+1 upward with wrap modulo NUM_REQ.
  - req_ready is one-hot for the granted i and 0 otherwise.
  - req_ready never asserts for a requester whose req_valid is low.
- Acceptance at edge T:
  - fpu_din1 <= req_a[i] and fpu_din2 <= req_b[i].
  - fpu_dval=1 for exactly the cycle after T.
  - ptr <= i.
  - Push tag i.
  - count increments.
  - At most one acceptance per cycle; back-to-back acceptances are allowed while count permits.
- fpu_din1/fpu_din2 hold their last value when no issue occurs.
- Completion:
  - On a cycle with fpu_rdy=1 and FIFO non-empty: pop tag t, resp_result <= fpu_result, resp_valid[t]=1 on the following cycle only, count decrements.
  - Issue-to-response latency = adder latency + 1 cycle of output register.
  - Responses have no backpressure; requesters must sample in the strobe cycle.
- Simultaneous accept and fpu_rdy in the same cycle: push and pop both occur and count is unchanged.
- fpu_rdy with FIFO empty: ignored (no resp_valid, count stays 0) and err_spurious <= 1. err_spurious clears only on reset.
- Tag FIFO: depth MAX_OUTSTANDING with wrapping read/write pointers. It cannot overflow because issue is gated by count.
- Fairness: a continuously requesting client is granted within NUM_REQ acceptances.
- Requester protocol: req_valid/req_a/req_b must hold stable until req_ready. Dropping req_valid before grant is allowed.

Test Plan:
- Single op: after reset, requester 0 sends a=0xc25acccd, b=0xc2786666 → req_ready[0] in the same cycle, fpu_dval next cycle with those operands, resp_valid=0001 and resp_result=0xc2e99999 one cycle after fpu_rdy; busy falls afterwards.
- All four requesters valid from the same cycle, MAX_OUTSTANDING=1 → grant order 0,1,2,3,0. Each new grant occurs only after the prior response. Each resp_valid bit matches its requester. 1.0+2.0 (0x3f800000+0x40000000) returns 0x40400000 to its issuer.
- MAX_OUTSTANDING=4 with a pipelined adder model: requesters 2,0,3 issue back-to-back → three consecutive fpu_dval pulses; responses strobe 0100, 0001, 1000 in order; a fifth request stalls (req_ready=0) while count=4.
- Same-cycle accept + fpu_rdy with count=1, MAX=1 → no accept that cycle (registered-count rule); accept occurs the next cycle; count never exceeds 1.
- Spurious fpu_rdy pulse while idle → no resp_valid, err_spurious=1 and stays set. A following normal op completes correctly.
- rst_n pulsed low between fpu_dval and fpu_rdy → all outputs return to reset values asynchronously. The post-reset fpu_rdy (if the model emits one) sets err_spurious and produces no resp_valid.

Source files
------------

// File: rtl/fpu_add_arbiter.sv
// fpu_add_arbiter: round-robin sharing of one fpu_sp_add adder between NUM_REQ
// requesters. An in-order tag FIFO records the issuer of every in-flight
// operation, so each adder completion is routed back to the requester that
// issued it.
module fpu_add_arbiter #(
  parameter int unsigned NUM_REQ         = 4,
  parameter int unsigned MAX_OUTSTANDING = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [32*NUM_REQ-1:0]  req_a,
  input  logic [32*NUM_REQ-1:0]  req_b,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [NUM_REQ-1:0]     resp_valid,
  output logic [31:0]            resp_result,
  output logic [31:0]            fpu_din1,
  output logic [31:0]            fpu_din2,
  output logic                   fpu_dval,
  input  logic [31:0]            fpu_result,
  input  logic                   fpu_rdy,
  output logic                   busy,
  output logic                   err_spurious
);

  localparam int unsigned TAG_W = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  logic                 run;
  logic [TAG_W-1:0]     rr_ptr;
  logic [CNT_W-1:0]     count;
  logic [TAG_W-1:0]     tag_mem [MAX_OUTSTANDING];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic                 eligible;
  logic                 grant_found;
  logic [TAG_W-1:0]     grant_idx;
  logic [TAG_W-1:0]     scan_idx;
  logic                 accept;
  logic                 pop;
  logic                 spurious;

  // Advance a tag FIFO pointer with wrap at the FIFO depth.
  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (32'(p) == MAX_OUTSTANDING - 1) ? '0 : p + 1'b1;
  endfunction

  // Round-robin search starting one past the last grant; gated by registered count.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    scan_idx    = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      scan_idx = TAG_W'((32'(rr_ptr) + k) % NUM_REQ);
      if (!grant_found && req_valid[scan_idx]) begin
        grant_found = 1'b1;
        grant_idx   = scan_idx;
      end
    end
    eligible  = run && (count < CNT_W'(MAX_OUTSTANDING));
    accept    = eligible && grant_found;
    req_ready = '0;
    if (accept) req_ready[grant_idx] = 1'b1;
  end

  assign pop      = fpu_rdy && (count != '0);
  assign spurious = fpu_rdy && (count == '0);
  assign busy     = (count != '0) || fpu_dval;

  // Holds req_ready low until the first clock after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) run <= 1'b0;
    else        run <= 1'b1;
  end

  // Issue path: capture granted operands, pulse dval, remember last winner.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fpu_din1 <= '0;
      fpu_din2 <= '0;
      fpu_dval <= 1'b0;
      rr_ptr   <= TAG_W'(NUM_REQ - 1);
    end else begin
      fpu_dval <= accept;
      if (accept) begin
        fpu_din1 <= req_a[32*32'(grant_idx) +: 32];
        fpu_din2 <= req_b[32*32'(grant_idx) +: 32];
        rr_ptr   <= grant_idx;
      end
    end
  end

  // In-order tag FIFO and outstanding-operation count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < MAX_OUTSTANDING; i++) tag_mem[i] <= '0;
    end else begin
      if (accept) begin
        tag_mem[wr_ptr] <= grant_idx;
        wr_ptr          <= ptr_next(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_next(rd_ptr);
      if (accept && !pop)      count <= count + 1'b1;
      else if (pop && !accept) count <= count - 1'b1;
    end
  end

  // Response routing: one-cycle strobe to the popped tag; sticky spurious flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid   <= '0;
      resp_result  <= '0;
      err_spurious <= 1'b0;
    end else begin
      resp_valid <= '0;
      if (pop) begin
        resp_valid[tag_mem[rd_ptr]] <= 1'b1;
        resp_result                 <= fpu_result;
      end
      if (spurious) err_spurious <= 1'b1;
    end
  end

endmodule
